// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, branch target LUT, start/stall/halt FSM
// Optional FETCH_PERF_CNT_EN adds saturating cycle_count/instr_count outputs.
module fetch_unit #(
    parameter int          PC_W       = 10,
    parameter int          LUT_AW     = 5,
    parameter logic [8:0]  HALT_INSTR = 9'h1FF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [8:0]        imem_data,
    output logic [8:0]        instr,
    output logic              instr_valid,
    output logic [PC_W-1:0]   pc,
    input  logic              stall,
    input  logic              branch,
    input  logic              branch_taken,
    input  logic              lut_we,
    input  logic [LUT_AW-1:0] lut_waddr,
    input  logic [PC_W-1:0]   lut_wdata,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]       cycle_count,
    output logic [31:0]       instr_count,
`endif
    output logic              done
);

    localparam int LUT_N = 2 ** LUT_AW;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALTED
    } state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   lut_q [LUT_N];
    logic [PC_W-1:0]   lut_d [LUT_N];
    logic [PC_W-1:0]   next_pc;
    logic              start_accept;

    assign start_accept = start && (state_q != S_RUN);

    // The branch reads the registered LUT, so a same-cycle write is seen only afterwards.
    always_comb begin
        next_pc = pc_q + PC_W'(1);
        if (stall) begin
            next_pc = pc_q;
        end else if (branch && branch_taken) begin
            next_pc = lut_q[imem_data[LUT_AW-1:0]];
        end
    end

    always_comb begin
        lut_d = lut_q;
        if (lut_we) begin
            lut_d[lut_waddr] = lut_wdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        imem_addr = '0;
        case (state_q)
            S_IDLE, S_HALTED: begin
                if (start) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                end
            end
            S_RUN: begin
                imem_addr = next_pc;
                pc_d      = next_pc;
                if (!stall && (imem_data == HALT_INSTR)) begin
                    state_d = S_HALTED;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            for (int i = 0; i < LUT_N; i++) begin
                lut_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            lut_q   <= lut_d;
        end
    end

    assign instr       = imem_data;
    assign instr_valid = (state_q == S_RUN);
    assign pc          = pc_q;
    assign done        = (state_q == S_HALTED);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] instr_cnt_q, instr_cnt_d;

    always_comb begin
        cycle_cnt_d = cycle_cnt_q;
        instr_cnt_d = instr_cnt_q;
        if (start_accept) begin
            cycle_cnt_d = '0;
            instr_cnt_d = '0;
        end else if (state_q == S_RUN) begin
            if (cycle_cnt_q != '1) begin
                cycle_cnt_d = cycle_cnt_q + 32'd1;
            end
            if (!stall && (instr_cnt_q != '1)) begin
                instr_cnt_d = instr_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign cycle_count = cycle_cnt_q;
    assign instr_count = instr_cnt_q;
`else
    logic unused_start_accept;
    assign unused_start_accept = start_accept;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  imem_addr;
    logic [8:0]  imem_data;
    logic [8:0]  instr;
    logic        instr_valid;
    logic [9:0]  pc;
    logic        stall;
    logic        branch;
    logic        branch_taken;
    logic        lut_we;
    logic [4:0]  lut_waddr;
    logic [9:0]  lut_wdata;
    logic        done;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] cycle_count;
    logic [31:0] instr_count;
`endif

    int checks = 0;
    int errors = 0;

    logic [8:0] mem [1024];

    fetch_unit dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .imem_addr    (imem_addr),
        .imem_data    (imem_data),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .pc           (pc),
        .stall        (stall),
        .branch       (branch),
        .branch_taken (branch_taken),
        .lut_we       (lut_we),
        .lut_waddr    (lut_waddr),
        .lut_wdata    (lut_wdata),
`ifdef FETCH_PERF_CNT_EN
        .cycle_count  (cycle_count),
        .instr_count  (instr_count),
`endif
        .done         (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_data <= mem[imem_addr];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic lut_write(input logic [4:0] a, input logic [9:0] d);
        lut_we = 1'b1; lut_waddr = a; lut_wdata = d;
        tick();
        lut_we = 1'b0;
    endtask

    task automatic run_to_halt(input string name);
        int n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL %s_halt_timeout: done=%b required 1", name, done); end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; stall = 1'b0; branch = 1'b0; branch_taken = 1'b0;
        lut_we = 1'b0; lut_waddr = '0; lut_wdata = '0;
        repeat (2) tick();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", instr_valid); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b required 0", done); end
        checks++; if (pc !== 10'd0) begin errors++; $display("FAIL rst_pc: got %0d required 0", pc); end
        checks++; if (imem_addr !== 10'd0) begin errors++; $display("FAIL rst_addr: got %0d required 0", imem_addr); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (cycle_count !== 32'd0) begin errors++; $display("FAIL rst_cycle_cnt: got %0d required 0", cycle_count); end
        checks++; if (instr_count !== 32'd0) begin errors++; $display("FAIL rst_instr_cnt: got %0d required 0", instr_count); end
`endif
        reset = 1'b0;
        tick();
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b required 0", instr_valid); end
    endtask

    task automatic test_sequential();
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            checks++; if (instr !== 9'(i + 1)) begin errors++; $display("FAIL seq_instr%0d: got %h required %h", i, instr, 9'(i + 1)); end
            checks++; if (pc !== 10'(i)) begin errors++; $display("FAIL seq_pc%0d: got %0d required %0d", i, pc, i); end
            checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL seq_valid%0d: got %b required 1", i, instr_valid); end
            checks++; if (imem_addr !== 10'(i + 1)) begin errors++; $display("FAIL seq_addr%0d: got %0d required %0d", i, imem_addr, i + 1); end
            tick();
        end
        checks++; if (instr !== 9'h1FF || done !== 1'b0) begin errors++; $display("FAIL halt_seen: instr=%h done=%b required 1ff/0", instr, done); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL halt_done: got %b required 1", done); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL halt_valid: got %b required 0", instr_valid); end
        checks++; if (imem_addr !== 10'd0) begin errors++; $display("FAIL halt_addr: got %0d required 0", imem_addr); end
        tick();
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL halt_level: got %b required 1", done); end
        pulse_start();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL restart_done: got %b required 0", done); end
        checks++; if (pc !== 10'd0 || instr !== 9'h001) begin errors++; $display("FAIL restart_fetch: pc=%0d instr=%h required 0/001", pc, instr); end
        run_to_halt("seq");
    endtask

    task automatic test_branch();
        lut_write(5'd3, 10'd40);
        pulse_start();
        tick();
        tick();
        checks++; if (instr !== 9'h003) begin errors++; $display("FAIL br_pre_instr: got %h required 003", instr); end
        branch = 1'b1; branch_taken = 1'b1;
        lut_we = 1'b1; lut_waddr = 5'd3; lut_wdata = 10'd50;
        #1;
        checks++; if (imem_addr !== 10'd40) begin errors++; $display("FAIL br_taken_addr: got %0d required 40", imem_addr); end
        tick();
        branch = 1'b0; branch_taken = 1'b0; lut_we = 1'b0;
        checks++; if (pc !== 10'd40 || instr !== 9'h0AA) begin errors++; $display("FAIL br_taken_pc: pc=%0d instr=%h required 40/0aa", pc, instr); end
        branch = 1'b1; branch_taken = 1'b0;
        #1;
        checks++; if (imem_addr !== 10'd41) begin errors++; $display("FAIL br_not_taken_addr: got %0d required 41", imem_addr); end
        tick();
        branch = 1'b0;
        checks++; if (pc !== 10'd41 || instr !== 9'h0AB) begin errors++; $display("FAIL br_not_taken_pc: pc=%0d instr=%h required 41/0ab", pc, instr); end
        run_to_halt("br1");
        pulse_start();
        tick();
        tick();
        branch = 1'b1; branch_taken = 1'b1;
        #1;
        checks++; if (imem_addr !== 10'd50) begin errors++; $display("FAIL br_new_entry_addr: got %0d required 50", imem_addr); end
        tick();
        branch = 1'b0; branch_taken = 1'b0;
        checks++; if (pc !== 10'd50 || instr !== 9'h055) begin errors++; $display("FAIL br_new_entry_pc: pc=%0d instr=%h required 50/055", pc, instr); end
        run_to_halt("br2");
    endtask

    task automatic test_stall();
        pulse_start();
        tick();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++; if (pc !== 10'd1 || instr !== 9'h002) begin errors++; $display("FAIL stall_hold%0d: pc=%0d instr=%h required 1/002", k, pc, instr); end
            if (k == 2) stall = 1'b0;
        end
        tick();
        checks++; if (pc !== 10'd2 || instr !== 9'h003) begin errors++; $display("FAIL stall_resume: pc=%0d instr=%h required 2/003", pc, instr); end
        tick();
        checks++; if (pc !== 10'd3 || instr !== 9'h004) begin errors++; $display("FAIL stall_next: pc=%0d instr=%h required 3/004", pc, instr); end
        tick();
        tick();
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++; if (done !== 1'b0 || instr_valid !== 1'b1 || pc !== 10'd5) begin errors++; $display("FAIL stall_halt%0d: done=%b valid=%b pc=%0d required 0/1/5", k, done, instr_valid, pc); end
        end
        stall = 1'b0;
        tick();
        checks++; if (done !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL stall_halt_release: done=%b valid=%b required 1/0", done, instr_valid); end
    endtask

    task automatic test_wrap();
        lut_write(5'd1, 10'd1023);
        pulse_start();
        branch = 1'b1; branch_taken = 1'b1;
        #1;
        checks++; if (imem_addr !== 10'd1023) begin errors++; $display("FAIL wrap_br_addr: got %0d required 1023", imem_addr); end
        tick();
        branch = 1'b0; branch_taken = 1'b0;
        checks++; if (pc !== 10'd1023 || instr !== 9'h0CC) begin errors++; $display("FAIL wrap_top: pc=%0d instr=%h required 1023/0cc", pc, instr); end
        checks++; if (imem_addr !== 10'd0) begin errors++; $display("FAIL wrap_addr: got %0d required 0", imem_addr); end
        tick();
        checks++; if (pc !== 10'd0 || instr !== 9'h001) begin errors++; $display("FAIL wrap_zero: pc=%0d instr=%h required 0/001", pc, instr); end
        run_to_halt("wrap");
    endtask

    task automatic test_reset_mid_run();
        pulse_start();
        tick();
        tick();
        #2 reset = 1'b1;
        #1;
        checks++; if (instr_valid !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL async_rst_flags: valid=%b done=%b required 0/0", instr_valid, done); end
        checks++; if (pc !== 10'd0 || imem_addr !== 10'd0) begin errors++; $display("FAIL async_rst_pc: pc=%0d addr=%0d required 0/0", pc, imem_addr); end
        #1 reset = 1'b0;
        tick();
        pulse_start();
        checks++; if (pc !== 10'd0 || instr !== 9'h001 || instr_valid !== 1'b1) begin errors++; $display("FAIL rst_refetch: pc=%0d instr=%h valid=%b required 0/001/1", pc, instr, instr_valid); end
        tick();
        tick();
        branch = 1'b1; branch_taken = 1'b1;
        #1;
        checks++; if (imem_addr !== 10'd0) begin errors++; $display("FAIL rst_lut_cleared: got %0d required 0", imem_addr); end
        tick();
        branch = 1'b0; branch_taken = 1'b0;
        checks++; if (pc !== 10'd0 || instr !== 9'h001) begin errors++; $display("FAIL rst_lut_target: pc=%0d instr=%h required 0/001", pc, instr); end
        run_to_halt("rst");
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        mem[5] = 9'h006; mem[6] = 9'h007; mem[7] = 9'h008; mem[8] = 9'h009; mem[9] = 9'h1FF;
        pulse_start();
        checks++; if (cycle_count !== 32'd0 || instr_count !== 32'd0) begin errors++; $display("FAIL perf_clear: cycles=%0d instrs=%0d required 0/0", cycle_count, instr_count); end
        tick(); tick(); tick();
        stall = 1'b1;
        tick(); tick();
        stall = 1'b0;
        run_to_halt("perf");
        checks++; if (cycle_count !== 32'd12) begin errors++; $display("FAIL perf_cycles: got %0d required 12", cycle_count); end
        checks++; if (instr_count !== 32'd10) begin errors++; $display("FAIL perf_instrs: got %0d required 10", instr_count); end
        tick(); tick();
        checks++; if (cycle_count !== 32'd12 || instr_count !== 32'd10) begin errors++; $display("FAIL perf_hold: cycles=%0d instrs=%0d required 12/10", cycle_count, instr_count); end
        mem[5] = 9'h1FF;
    endtask
`endif

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 9'h100;
        mem[0] = 9'h001; mem[1] = 9'h002; mem[2] = 9'h003; mem[3] = 9'h004; mem[4] = 9'h005;
        mem[5] = 9'h1FF;
        mem[40] = 9'h0AA; mem[41] = 9'h0AB; mem[42] = 9'h1FF;
        mem[50] = 9'h055; mem[51] = 9'h1FF;
        mem[1023] = 9'h0CC;
        @(negedge clk);
        test_reset();
        test_sequential();
        test_branch();
        test_stall();
        test_wrap();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage for the 9-bit single-issue core. It owns the program counter, drives the synchronous instruction memory, and presents one instruction per cycle to the control decoder. It also resolves taken branches through an internal target lookup table, and handles stall, halt and restart. It sits directly upstream of the control decoder and takes the decoder's `branch` output and the ALU's condition result back as inputs.

## Interface
Parameters:
- `PC_W`, default 10: program counter and instruction address width.
- `LUT_AW`, default 5: branch target LUT index width; the LUT has 2^LUT_AW entries of PC_W bits.
- `HALT_INSTR`, default 9'h1FF: reserved encoding that ends execution.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle pulse that begins execution at address 0.
- `imem_addr`  out  PC_W  instruction memory read address; data returns on the next cycle.
- `imem_data`  in  9  instruction memory read data.
- `instr`  out  9  instruction to the decoder; equals `imem_data`.
- `instr_valid`  out  1  `instr` is a live instruction.
- `pc`  out  PC_W  address of `instr`.
- `stall`  in  1  downstream hold.
- `branch`  in  1  from the decoder: current instruction is a branch.
- `branch_taken`  in  1  branch condition true this cycle.
- `lut_we`  in  1  branch LUT write enable.
- `lut_waddr`  in  LUT_AW  LUT write index.
- `lut_wdata`  in  PC_W  LUT write target.
- `done`  out  1  halt reached; a level, not a pulse.

## Operation
- Three-state FSM.
  - IDLE
    - `start` moves the FSM to RUN.
  - RUN
    - A non-stalled `instr_valid` cycle with `instr`==HALT_INSTR moves the FSM to HALTED.
    - `start` is ignored in RUN.
  - HALTED
    - `start` moves the FSM to RUN and clears `done` on the same edge.
- `instr_valid` = (state==RUN).
- `imem_addr` in IDLE and HALTED: 0.
- `imem_addr` in RUN: `next_pc`, combinational. Priority order:
  1. `stall` → `pc`. The same address is re-read, so `instr` holds.
  2. `branch & branch_taken` → `lut[instr[LUT_AW-1:0]]`.
  3. Otherwise → `pc+1`, wrapping modulo 2^PC_W.
- `pc` <= `next_pc` on every RUN edge.
- `pc` <= 0 on entry to RUN.
- A halt instruction under `stall` does not halt until `stall` deasserts.
- A branch with `branch_taken`=0 falls through to `pc+1`.
- LUT write occurs on the clock edge and is accepted in every state.
- A write and a branch read to the same index in the same cycle: the branch uses the old entry.

## Timing
- Reset values: state IDLE, `pc`=0, `instr_valid`=0, `done`=0, `imem_addr`=0, all LUT entries 0, counters 0.
- Start latency: `start` high at edge N gives `instr_valid`=1 with `instr`=mem[0] in cycle N+1. Address 0 was presented during IDLE.
- Throughput: one instruction per non-stalled cycle.
- Taken branch: zero bubbles; the target instruction is valid in the next cycle.
- Halt: the halt instruction is seen in cycle H. From cycle H+1:
  - `done`=1
  - `instr_valid`=0
  - `imem_addr`=0
- Reset mid-RUN: all registers clear immediately, with no clock needed; the LUT contents are also lost.
- Wrap-around: `pc`=2^PC_W−1 non-branch → `pc`=0.

## Configuration
- `FETCH_PERF_CNT_EN` defined: adds two 32-bit outputs.
  - `cycle_count`: increments on every RUN cycle.
  - `instr_count`: increments on every `instr_valid & !stall` cycle.
  - Both saturate at 32'hFFFFFFFF.
  - Both clear on reset and on an accepted `start`.
  - Both hold in HALTED.
- `FETCH_PERF_CNT_EN` undefined: the ports and counters are absent; behaviour is otherwise identical.

## Test plan
- Reset, then pulse `start` with mem[0..3]=9'h001..9'h004 → `instr` sequence 001, 002, 003, 004 on consecutive cycles; `pc` 0, 1, 2, 3.
- Write lut[3]=10'd40, then execute a branch with `instr[4:0]`=3 and `branch_taken`=1 → next cycle `pc`=40. With `branch_taken`=0 → `pc`+1.
- Assert `stall` for 3 cycles mid-stream → `instr` and `pc` hold for 3 cycles, then resume at `pc+1` with no instruction lost or duplicated.
- Place HALT_INSTR at address 5 → `done`=1 and `instr_valid`=0 from the cycle after; a later `start` restarts at `pc`=0 and clears `done`.
- Assert `reset` mid-RUN between clock edges → all outputs return to reset values before the next edge; `start` then refetches mem[0].
- With `FETCH_PERF_CNT_EN`, run 10 instructions including 2 stall cycles, then halt → `cycle_count`=12, `instr_count`=10.
